sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO. It is the next-generation buffer for Tiny Tapeout designs in this codebase.
- Generalised in data width and depth.
- Adds, over the earlier fixed 4-bit × 8 buffer:
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - optional first-word-fall-through read mode
- Sits between a top-level pin wrapper (ui_in/uo_out) and a producer/consumer pair that share one clock.

Parameters:
- DATA_WIDTH, 4, bits per entry (≥1).
- ADDR_WIDTH, 3, log2 of depth. DEPTH = 2**ADDR_WIDTH (≥2 entries).
- AF_THRESH, 6, almost_full asserts when count ≥ AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop).
- clr_err  in  1  synchronous clear of overflow and underflow.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data qualifier.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0 and count = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1; almost_full = 0 (AF_THRESH ≥ 1).
  - Memory contents are not reset.
  - Reset mid-operation discards all stored entries immediately.
- Accept rules:
  - wr_ok = wr_en & ~full
  - rd_ok = rd_en & ~empty
  - Both use the registered flags of the current cycle.
  - When full, a simultaneous read and write: the read is accepted and the write is rejected (overflow sets).
  - When empty, a simultaneous read and write: the write is accepted and the read is rejected (underflow sets).
- Pointers:
  - ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
  - Each pointer increments by 1 on its accept and wraps modulo 2·DEPTH.
- Count update:
  - +1 on wr_ok only.
  - −1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- Flags:
  - full, empty, almost_full and almost_empty are decoded from the registered count only.
  - There is no combinational path from wr_en or rd_en to any flag.
- Memory write: mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data on wr_ok.
- Registered read (default):
  - On rd_ok, rd_data <= mem[rd_ptr] and rd_valid = 1 on the following cycle.
  - Latency is 1 cycle from the rd_en edge.
  - rd_valid is a one-cycle pulse per accepted read.
  - rd_data holds its last value otherwise.
- Error flags:
  - overflow sets when wr_en & full; underflow sets when rd_en & empty.
  - Both clear on clr_err.
  - If set and clear occur in the same cycle, set wins.
- Rejected accesses change no pointer, count or memory state.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]], decoded from registered state.
  - rd_valid = ~empty.
  - rd_en acts as an acknowledge/pop: the next entry, if any, is presented on the cycle after rd_ok.
  - A write into an empty FIFO appears on rd_data, with rd_valid = 1, on the cycle after wr_ok.
  - rd_data value while empty is don't-care.
- Undefined: registered-read behaviour as above.
- Flags, count and error logic are identical in both modes.

Test Plan (DATA_WIDTH=4, ADDR_WIDTH=3, AF=6, AE=1):
1. Reset then idle -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0, overflow=0, underflow=0. Assert rst_n=0 mid-stream with count=5 -> count=0 and empty=1 with no clock edge required.
2. Write 1,2,…,8 on 8 consecutive cycles -> count steps 1..8, almost_full rises when count=6, full=1 when count=8. A 9th write -> count stays 8, overflow=1. clr_err -> overflow=0.
3. From full, read 8 times (registered mode) -> rd_valid pulses carry 1..8 in order, each one cycle after its rd_en. empty=1 after the last read. A further read -> underflow=1, rd_data holds 8.
4. Wrap-around: write 5, read 5, write 8 values A..H, read 8 -> output A..H in order. Pointers cross the wrap bit and count never exceeds 8.
5. Simultaneous rd_en & wr_en at count=4 -> count stays 4 and order is preserved. At count=8 -> read accepted, write rejected, overflow=1, count=7. At count=0 -> write accepted, read rejected, underflow=1, count=1.
6. With SYNC_FIFO_FWFT_EN defined: write 0xA into an empty FIFO -> next cycle rd_valid=1 and rd_data=0xA without rd_en. Write 0xB, then rd_en -> next cycle rd_data=0xB. rd_en again -> rd_valid=0, empty=1.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: the producer/consumer side uses
// "master" and the FIFO uses "slave". Clock and reset stay plain ports on the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses registered reads.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);
  localparam logic [PW-1:0] ZERO_C  = PW'(0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         count_r;
  logic [PW-1:0]         count_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  almost_full_r;
  logic                  almost_empty_r;
  logic                  overflow_r;
  logic                  underflow_r;

  assign wr_addr_s = wr_ptr_r[ADDR_WIDTH-1:0];
  assign rd_addr_s = rd_ptr_r[ADDR_WIDTH-1:0];

  // Accept decisions from registered flags, and the occupancy that results.
  always_comb begin
    wr_ok_s = bus.wr_en & ~full_r;
    rd_ok_s = bus.rd_en & ~empty_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_s = count_r + ONE_C;
      2'b01:   count_s = count_r - ONE_C;
      default: count_s = count_r;
    endcase
  end

  // Pointers and count; pointers carry a wrap bit and roll over modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= ZERO_C;
      rd_ptr_r <= ZERO_C;
      count_r  <= ZERO_C;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_s;
    end
  end

  // Status flags track the count register exactly; they are precomputed from
  // the next count so that no request input reaches a flag combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      full_r         <= (count_s == DEPTH_C);
      empty_r        <= (count_s == ZERO_C);
      almost_full_r  <= (count_s >= AF_C);
      almost_empty_r <= (count_s <= AE_C);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.wr_en & full_r) begin
        overflow_r <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (bus.rd_en & empty_r) begin
        underflow_r <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  // Storage array; contents survive reset and are only ever written on accept.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[wr_addr_s] <= bus.wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem[rd_addr_s];
  assign bus.rd_valid = ~empty_r;
`else
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  // Registered read port: one-cycle valid pulse per pop, data held between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      if (rd_ok_s) begin
        rd_data_r <= mem[rd_addr_s];
      end else begin
        rd_data_r <= rd_data_r;
      end
      rd_valid_r <= rd_ok_s;
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
`endif

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: directed scenarios plus randomized traffic
// against a queue-based reference model; a negedge monitor checks every cycle.
module tb_sync_fifo_param;
  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit            m_rv;
  bit            m_ovf;
  bit            m_udf;
  logic [DW-1:0] last_rd;
  logic [DW-1:0] mon_e;

  bit            p_wr;
  bit            p_rd;
  bit            p_clr;
  logic [DW-1:0] p_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs that were driven for it.
  task automatic apply_model();
    int  n;
    bit  wok;
    bit  rok;
    logic [DW-1:0] v;
    n   = model_q.size();
    wok = p_wr && (n != DEPTH);
    rok = p_rd && (n != 0);
    if (rok) begin
      v = model_q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
      exp_q.push_back(v);
`endif
    end
    if (wok) model_q.push_back(p_d);
    m_rv = rok;
    if (p_wr && n == DEPTH) m_ovf = 1'b1;
    else if (p_clr)         m_ovf = 1'b0;
    if (p_rd && n == 0)     m_udf = 1'b1;
    else if (p_clr)         m_udf = 1'b0;
  endtask

  task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
    @(posedge clk);
    #1;
    apply_model();
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    p_wr = wr; p_d = d; p_rd = rd; p_clr = clr;
  endtask

  task automatic wr_n(input int n, input int base);
    for (int i = 0; i < n; i++) cycle(1'b1, DW'(base + i), 1'b0, 1'b0);
  endtask

  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clear_model();
    model_q.delete();
    exp_q.delete();
    m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    last_rd = '0;
    p_wr = 1'b0; p_rd = 1'b0; p_clr = 1'b0; p_d = '0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.wr_data = '0;
  endtask

  // Reset asserted between edges must clear state without waiting for a clock.
  task automatic reset_mid();
    cycle(1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_count", 32'(bus.count), 32'd0);
    chk("rst_async_empty", 32'(bus.empty), 32'd1);
    chk("rst_async_full", 32'(bus.full), 32'd0);
    chk("rst_async_rd_valid", 32'(bus.rd_valid), 32'd0);
    clear_model();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every DUT output against the model in mid-cycle.
  always @(negedge clk) begin
    int n;
    n = model_q.size();
    chk("count", 32'(bus.count), 32'(n));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd_valid", 32'(bus.rd_valid), 32'(n != 0));
    if (n != 0) chk("fwft_rd_data", 32'(bus.rd_data), 32'(model_q[0]));
`else
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(bus.rd_data), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(mon_e));
        last_rd = mon_e;
      end
    end else begin
      chk("rd_data_hold", 32'(bus.rd_data), 32'(last_rd));
    end
`endif
  end

  initial begin
    int wp;
    int rp;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset, then fill past full, clear the error, drain past empty.
    rd_n(0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    wr_n(8, 1);
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    rd_n(8);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Wrap-around of both pointers.
    wr_n(5, 3);
    rd_n(5);
    wr_n(8, 10);
    rd_n(8);

    // Simultaneous read and write at mid, full and empty occupancy.
    wr_n(4, 1);
    cycle(1'b1, 4'h5, 1'b1, 1'b0);
    cycle(1'b1, 4'h6, 1'b1, 1'b0);
    wr_n(4, 7);
    cycle(1'b1, 4'hE, 1'b1, 1'b0);
    rd_n(7);
    cycle(1'b1, 4'hC, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    rd_n(1);

    // Fall-through style sequence (also valid in registered mode).
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 4'hB, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Reset with five entries stored.
    wr_n(5, 2);
    reset_mid();
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic in phases biased toward filling, draining and mixing.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0:       begin wp = 80; rp = 25; end
        1:       begin wp = 25; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      for (int i = 0; i < 120; i++) begin
        cycle($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < rp,
              $urandom_range(15) == 0);
      end
    end

    rd_n(DEPTH + 1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    apply_model();
    p_wr = 1'b0; p_rd = 1'b0; p_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
